// File: rtl/rou_sched.sv
// Ring output scheduler: shares one downstream link between ring pass-through
// and two local requesters, with starvation relief and busy backoff/retry.
module rou_sched #(
    parameter int DWID    = 128,
    parameter int AWID    = 32,
    parameter int CWID    = 8,
    parameter int WID     = 2 + DWID + AWID + CWID,
    parameter int STARVE  = 4,
    parameter int BACKOFF = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WID-1:0] rou_in,
    output logic [2:0]     ack_in,
    output logic [WID-1:0] rou_out,
    input  logic [2:0]     ack_out,
    input  logic [WID-1:0] loc0_flit,
    input  logic [WID-1:0] loc1_flit,
    input  logic           loc0_vld,
    input  logic           loc1_vld,
    output logic           loc0_gnt,
    output logic           loc1_gnt,
    output logic           err_drop
);

    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam int BW = (BACKOFF < 1) ? 1 : $clog2(BACKOFF + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [BW-1:0] BACKOFF_LD = BW'(BACKOFF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_BACKOFF
    } state_t;

    state_t         state;
    logic [SW-1:0]  starve_cnt;
    logic [BW-1:0]  bo_cnt;
    logic           rr_next;
    logic [WID-1:0] hold;

    logic [1:0] ring_kind;
    logic       ring_cand;
    logic       loc_any;
    logic       force_loc;
    logic       grant_ring;
    logic       grant_loc;
    logic       pick_loc1;

    always_comb begin
        ring_kind  = rou_in[WID-1:WID-2];
        ring_cand  = ring_kind[1] ^ ring_kind[0];
        loc_any    = loc0_vld | loc1_vld;
        force_loc  = loc_any && (starve_cnt == STARVE_MAX);
        grant_ring = (state == S_IDLE) && ring_cand && !force_loc;
        grant_loc  = (state == S_IDLE) && loc_any && !grant_ring;
        // rr_next names the local favoured when both are waiting
        pick_loc1  = loc1_vld && (!loc0_vld || rr_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rou_out    <= '0;
            ack_in     <= '0;
            loc0_gnt   <= 1'b0;
            loc1_gnt   <= 1'b0;
            err_drop   <= 1'b0;
            starve_cnt <= '0;
            bo_cnt     <= '0;
            rr_next    <= 1'b0;
            hold       <= '0;
        end else begin
            loc0_gnt <= 1'b0;
            loc1_gnt <= 1'b0;
            err_drop <= 1'b0;

            case (ring_kind)
                2'b00:   ack_in <= 3'b000;
                2'b11:   ack_in <= 3'b100;
                default: ack_in <= grant_ring ? 3'b001 : 3'b010;
            endcase

            case (state)
                S_IDLE: begin
                    if (grant_ring) begin
                        rou_out <= rou_in;
                        state   <= S_SEND;
                        if (loc_any && (starve_cnt != STARVE_MAX))
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_loc) begin
                        rou_out    <= pick_loc1 ? loc1_flit : loc0_flit;
                        loc0_gnt   <= !pick_loc1;
                        loc1_gnt   <= pick_loc1;
                        rr_next    <= !pick_loc1;
                        starve_cnt <= '0;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (ack_out[2]) begin
                        rou_out  <= '0;
                        hold     <= '0;
                        err_drop <= 1'b1;
                        state    <= S_IDLE;
                    end else if (ack_out[0]) begin
                        rou_out <= '0;
                        hold    <= '0;
                        state   <= S_IDLE;
                    end else if (ack_out[1]) begin
                        hold    <= rou_out;
                        rou_out <= '0;
                        bo_cnt  <= BACKOFF_LD;
                        state   <= S_BACKOFF;
                    end
                end
                S_BACKOFF: begin
                    // re-drive on the edge where the count would reach zero
                    if (bo_cnt <= BW'(1)) begin
                        rou_out <= hold;
                        bo_cnt  <= '0;
                        state   <= S_SEND;
                    end else begin
                        bo_cnt <= bo_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rou_sched.sv
// Bench for rou_sched: directed scenarios plus random traffic, all checked
// against a transaction-level model of the link owner.
module tb_rou_sched;

    localparam int DWID    = 128;
    localparam int AWID    = 32;
    localparam int CWID    = 8;
    localparam int WID     = 2 + DWID + AWID + CWID;
    localparam int STARVE  = 4;
    localparam int BACKOFF = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [WID-1:0] rou_in, rou_out, loc0_flit, loc1_flit;
    logic [2:0]     ack_in, ack_out;
    logic           loc0_vld, loc1_vld, loc0_gnt, loc1_gnt, err_drop;

    always #5 clk = ~clk;

    rou_sched #(
        .DWID(DWID), .AWID(AWID), .CWID(CWID), .WID(WID),
        .STARVE(STARVE), .BACKOFF(BACKOFF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rou_in(rou_in), .ack_in(ack_in),
        .rou_out(rou_out), .ack_out(ack_out),
        .loc0_flit(loc0_flit), .loc1_flit(loc1_flit),
        .loc0_vld(loc0_vld), .loc1_vld(loc1_vld),
        .loc0_gnt(loc0_gnt), .loc1_gnt(loc1_gnt),
        .err_drop(err_drop)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Model: who owns the link (0 free, 1 flit on wire, 2 waiting to retry)
    int             m_mode, m_left, m_starve, m_turn;
    logic [WID-1:0] m_out, m_hold;
    logic [2:0]     m_ack;
    logic           m_g0, m_g1, m_err;

    function automatic void model_reset();
        m_mode = 0; m_left = 0; m_starve = 0; m_turn = 0;
        m_out = '0; m_hold = '0; m_ack = '0;
        m_g0 = 0; m_g1 = 0; m_err = 0;
    endfunction

    function automatic void model_step();
        logic [1:0] k = rou_in[WID-1 -: 2];
        bit ring_req = (k == 2'b01) || (k == 2'b10);
        bit locs = loc0_vld || loc1_vld;
        m_g0 = 0; m_g1 = 0; m_err = 0;
        m_ack = (k == 2'b00) ? 3'b000 : (k == 2'b11) ? 3'b100 : 3'b010;
        if (m_mode == 0) begin
            if (ring_req && !(locs && m_starve >= STARVE)) begin
                m_out = rou_in; m_ack = 3'b001; m_mode = 1;
                if (locs && m_starve < STARVE) m_starve++;
            end else if (locs) begin
                if (loc0_vld && (!loc1_vld || m_turn == 0)) begin
                    m_out = loc0_flit; m_g0 = 1; m_turn = 1;
                end else begin
                    m_out = loc1_flit; m_g1 = 1; m_turn = 0;
                end
                m_starve = 0; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (ack_out[2]) begin
                m_out = '0; m_err = 1; m_mode = 0;
            end else if (ack_out[0]) begin
                m_out = '0; m_mode = 0;
            end else if (ack_out[1]) begin
                m_hold = m_out; m_out = '0; m_mode = 2;
                m_left = (BACKOFF < 1) ? 1 : BACKOFF;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_out = m_hold; m_mode = 1;
            end
        end
    endfunction

    task automatic check_outputs();
        chk("rou_out", rou_out, m_out);
        chk("ack_in", ack_in, m_ack);
        chk("loc0_gnt", loc0_gnt, m_g0);
        chk("loc1_gnt", loc1_gnt, m_g1);
        chk("err_drop", err_drop, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [WID-1:0] rand_flit(input logic [1:0] kind);
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return {kind, r[WID-3:0]};
    endfunction

    function automatic logic [1:0] ring_kind_pick();
        int unsigned r = $urandom_range(0, 19);
        if (r < 5) return 2'b00;
        if (r < 17) return (r[0]) ? 2'b01 : 2'b10;
        return 2'b11;
    endfunction

    task automatic drain();
        rou_in = '0; loc0_vld = 0; loc1_vld = 0; ack_out = 3'b001;
        repeat (3) tick();
        ack_out = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WID-1:0] f;
        int order[$];
        int cyc[$];
        int n, zeros;
        bit got;

        rst_n = 0; rou_in = '0; ack_out = '0;
        loc0_flit = '0; loc1_flit = '0; loc0_vld = 0; loc1_vld = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1;
        tick();

        // Ring-only forwarding
        f = {2'b01, (WID-2)'(8'hA5)};
        rou_in = f;
        tick();
        chk("t1_fwd", rou_out, f);
        chk("t1_ack", ack_in, 3'b001);
        rou_in = '0; ack_out = 3'b001;
        tick();
        chk("t1_clear", rou_out, '0);
        ack_out = 3'b000;
        tick();

        // Both locals: loc0 then loc1, one idle cycle between flits
        loc0_flit = rand_flit(2'b01); loc1_flit = rand_flit(2'b10);
        loc0_vld = 1; loc1_vld = 1; ack_out = 3'b001;
        for (int i = 0; i < 12 && order.size() < 2; i++) begin
            tick();
            if (loc0_gnt) begin order.push_back(0); cyc.push_back(i); loc0_vld = 0; end
            if (loc1_gnt) begin order.push_back(1); cyc.push_back(i); loc1_vld = 0; end
        end
        chk("t2_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("t2_first", order[0], 0);
            chk("t2_second", order[1], 1);
            chk("t2_gap", cyc[1] - cyc[0], 2);
        end
        drain();

        // Starvation relief
        loc0_flit = rand_flit(2'b01); loc0_vld = 1;
        rou_in = rand_flit(2'b01); ack_out = 3'b001;
        n = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (ack_in == 3'b001) begin n++; rou_in = rand_flit(2'b01); end
            if (loc0_gnt) begin
                got = 1; loc0_vld = 0;
                chk("t3_lost_ack", ack_in, 3'b010);
            end
        end
        chk("t3_gnt_seen", got, 1);
        chk("t3_ring_grants", n, STARVE);
        drain();

        // Busy backoff then accept via 011
        f = rand_flit(2'b10);
        loc0_flit = f; loc0_vld = 1;
        tick();
        loc0_vld = 0; ack_out = 3'b010;
        tick();
        ack_out = 3'b111;
        zeros = (rou_out == '0) ? 1 : 0;
        for (int i = 0; i < 10 && rou_out == '0; i++) begin
            tick();
            if (rou_out == '0) zeros++;
        end
        chk("t4_zero_cycles", zeros, BACKOFF);
        chk("t4_redrive", rou_out, f);
        ack_out = 3'b011;
        tick();
        chk("t4_acc011", rou_out, '0);
        ack_out = 3'b000;
        tick();

        // Downstream error and illegal ring kind
        loc1_flit = rand_flit(2'b01); loc1_vld = 1;
        tick();
        loc1_vld = 0; ack_out = 3'b111;
        tick();
        chk("t5_err_drop", err_drop, 1);
        chk("t5_err_out", rou_out, '0);
        ack_out = 3'b000;
        tick();
        chk("t5_err_pulse", err_drop, 0);
        rou_in = rand_flit(2'b11);
        repeat (3) begin
            tick();
            chk("t5_ill_ack", ack_in, 3'b100);
            chk("t5_ill_out", rou_out, '0);
        end
        rou_in = '0;
        tick();

        // Reset during backoff
        loc0_flit = rand_flit(2'b01); loc0_vld = 1;
        tick();
        loc0_vld = 0; ack_out = 3'b010;
        tick();
        ack_out = 3'b000;
        tick();
        f = rand_flit(2'b10);
        loc0_flit = f; loc0_vld = 1;
        rst_n = 0;
        model_reset();
        #1;
        check_outputs();
        chk("t6_rst_out", rou_out, '0);
        tick();
        rst_n = 1;
        tick();
        chk("t6_gnt", loc0_gnt, 1);
        chk("t6_fwd", rou_out, f);
        loc0_vld = 0;
        drain();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (ack_in != 3'b010) rou_in = rand_flit(ring_kind_pick());
            if (loc0_gnt) loc0_vld = 0;
            if (loc1_gnt) loc1_vld = 0;
            if (!loc0_vld && $urandom_range(0, 3) == 0) begin
                loc0_vld = 1; loc0_flit = rand_flit($urandom_range(0, 1) ? 2'b01 : 2'b10);
            end
            if (!loc1_vld && $urandom_range(0, 3) == 0) begin
                loc1_vld = 1; loc1_flit = rand_flit($urandom_range(0, 1) ? 2'b01 : 2'b10);
            end
            case ($urandom_range(0, 7))
                0, 7:    ack_out = 3'b000;
                1, 2:    ack_out = 3'b001;
                3:       ack_out = 3'b010;
                4:       ack_out = 3'b011;
                5:       ack_out = 3'b100;
                default: ack_out = 3'b111;
            endcase
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rou_sched.md
ROU_SCHED -- requirements
Module: rou_sched

Interface
REQ-001 Parameter DWID, default 128, data field width.
REQ-002 Parameter AWID, default 32, address field width.
REQ-003 Parameter CWID, default 8, command field width.
REQ-004 Parameter WID, default 2+DWID+AWID+CWID, flit width; flit[WID-1:WID-2] is the kind field: 00 idle, 01 request, 10 response, 11 illegal.
REQ-005 Parameter STARVE, default 4, consecutive ring grants before local traffic is forced in.
REQ-006 Parameter BACKOFF, default 3, idle cycles before resending a flit after a busy ack.
REQ-007 clk  input  1  single clock; all state updates on posedge clk.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 rou_in  input  WID  upstream ring flit; held by upstream until acked.
REQ-010 ack_in  output  3  registered ack to upstream: bit0 accept, bit1 busy, bit2 error.
REQ-011 rou_out  output  WID  registered downstream flit; all-zero when idle.
REQ-012 ack_out  input  3  downstream ack: bit0 accept, bit1 busy, bit2 error.
REQ-013 loc0_flit / loc1_flit  input  WID  local requester flits.
REQ-014 loc0_vld / loc1_vld  input  1  local flit valid; held until matching gnt.
REQ-015 loc0_gnt / loc1_gnt  output  1  registered one-cycle grant pulse.
REQ-016 err_drop  output  1  registered one-cycle pulse when an in-flight flit is dropped on downstream error.

Function
REQ-017 The block SHALL share the single rou_out link between ring pass-through (rou_in) and two local requesters, holding one flit at a time.
REQ-018 FSM states SHALL be IDLE, SEND, BACKOFF.
REQ-019 In IDLE, candidates SHALL be: ring if rou_in kind is 01 or 10; locN if locN_vld=1.
REQ-020 Default priority in IDLE SHALL be ring over locals; locals SHALL alternate round-robin via a last-granted pointer (loc0 first after reset).
REQ-021 Starve counter SHALL count ring grants made while any loc_vld=1, saturate at STARVE, and reset on any local grant; when equal to STARVE, a waiting local SHALL win over ring.
REQ-022 On a grant in IDLE, the winning flit SHALL be loaded into rou_out at that clock edge and state SHALL become SEND.
REQ-023 Ring grant SHALL produce ack_in=001 in the following cycle; local grant SHALL produce locN_gnt=1 in the following cycle.
REQ-024 Sampled ring flit with kind 01/10 not granted (state not IDLE, or lost arbitration) SHALL produce ack_in=010 next cycle.
REQ-025 Ring flit with kind 11 SHALL never be granted and SHALL produce ack_in=100 next cycle; kind 00 produces ack_in=000.
REQ-026 In SEND, ack_out decode priority SHALL be error > accept > busy; ack_out=000 keeps SEND with rou_out unchanged.
REQ-027 SEND + ack_out[2]: flit discarded, rou_out=0, err_drop pulse next cycle, state IDLE.
REQ-028 SEND + ack_out[0]: rou_out=0, state IDLE; no new grant in the same cycle (minimum one IDLE cycle between flits).
REQ-029 SEND + ack_out[1]: rou_out=0, flit retained in an internal hold register, backoff counter loaded with BACKOFF, state BACKOFF.
REQ-030 BACKOFF SHALL decrement each cycle; at zero the held flit SHALL be re-driven on rou_out and state SHALL become SEND; ack_out SHALL be ignored in BACKOFF.
REQ-031 Retry count SHALL be unbounded; no new grant occurs outside IDLE.

Reset
REQ-032 While rst_n=0: state IDLE, rou_out=0, ack_in=000, loc0_gnt=loc1_gnt=0, err_drop=0, starve counter 0, backoff counter 0, RR pointer to loc0, hold register 0.
REQ-033 Reset asserted mid-SEND or mid-BACKOFF SHALL discard the in-flight flit with no err_drop pulse.

Verification
REQ-034 Ring only: rou_in kind 01, data A5 -> next edge rou_out=flit, ack_in=001 for one cycle; ack_out=001 -> rou_out=0 next cycle.
REQ-035 Both locals valid, ring idle: loc0 granted first, after its ack_out accept loc1 granted; gnt pulses exactly one cycle each.
REQ-036 Ring continuously valid, loc0_vld=1, STARVE=4: four ring grants then loc0 granted on fifth arbitration; ack_in=010 for the ring flit in that cycle.
REQ-037 ack_out=010 in SEND -> rou_out=0 for exactly 3 cycles then same flit re-driven; ack_out=011 treated as accept.
REQ-038 ack_out=111 in SEND -> rou_out=0, err_drop=1 one cycle; rou_in kind 11 -> ack_in=100, never forwarded.
REQ-039 rst_n low during BACKOFF -> all outputs zero immediately; after release, pending loc0 granted normally.
